// File: rtl/roi_axis_frame_source.sv
// AXI-Stream raster frame source: emits WIDTH x HEIGHT pixel frames with SOF on tuser and EOL on tlast.
// Supports single-shot or free-running frames, four test patterns and optional inter-line blanking.
module roi_axis_frame_source #(
  parameter int PIXEL_SIZE = 8,
  parameter int WIDTH      = 1920,
  parameter int HEIGHT     = 1080,
  parameter int HBLANK     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_pattern,
  input  logic [PIXEL_SIZE-1:0] i_const,
  input  logic                  i_continuous,
  input  logic                  i_stop,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [PIXEL_SIZE-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  output logic                  o_m_axis_tlast,
  output logic                  o_m_axis_tuser,
  input  logic                  i_m_axis_tready
);

  // state    | meaning
  // S_IDLE   | waiting for i_start, stream quiet
  // S_ACTIVE | presenting pixel (x,y), advancing on each beat
  // S_BLANK  | HBLANK idle cycles between lines
  // S_DONE   | one-cycle end of frame: frame_done pulse, restart or stop

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [BW-1:0] B_INIT = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK, S_DONE} state_t;

  state_t                state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [BW-1:0]         blank_cnt;
  logic [PIXEL_SIZE-1:0] frame_cnt;
  logic [1:0]            pattern_q;
  logic [PIXEL_SIZE-1:0] const_q;
  logic                  cont_q;
  logic                  stop_flag;

  // Checker bit 3 is taken from zero-extended coordinates so narrow x/y still work.
  function automatic logic [PIXEL_SIZE-1:0] pix(
    input logic [1:0]            p,
    input logic [PIXEL_SIZE-1:0] c,
    input logic [PIXEL_SIZE-1:0] f,
    input logic [XW-1:0]         px,
    input logic [YW-1:0]         py
  );
    case (p)
      2'd0:    pix = PIXEL_SIZE'(32'(px) + 32'(py));
      2'd1:    pix = (((32'(px) ^ 32'(py)) & 32'd8) != 32'd0) ? '1 : '0;
      2'd2:    pix = c;
      default: pix = f;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      x               <= '0;
      y               <= '0;
      blank_cnt       <= '0;
      frame_cnt       <= '0;
      pattern_q       <= '0;
      const_q         <= '0;
      cont_q          <= 1'b0;
      stop_flag       <= 1'b0;
      o_busy          <= 1'b0;
      o_frame_done    <= 1'b0;
      o_m_axis_tdata  <= '0;
      o_m_axis_tvalid <= 1'b0;
      o_m_axis_tlast  <= 1'b0;
      o_m_axis_tuser  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_stop && (state != S_IDLE)) stop_flag <= 1'b1;

      case (state)
        S_IDLE: begin
          stop_flag <= 1'b0;
          if (i_start) begin
            pattern_q       <= i_pattern;
            const_q         <= i_const;
            cont_q          <= i_continuous;
            x               <= '0;
            y               <= '0;
            state           <= S_ACTIVE;
            o_busy          <= 1'b1;
            o_m_axis_tvalid <= 1'b1;
            o_m_axis_tuser  <= 1'b1;
            o_m_axis_tlast  <= 1'b0;
            o_m_axis_tdata  <= pix(i_pattern, i_const, frame_cnt, '0, '0);
          end
        end

        S_ACTIVE: begin
          if (i_m_axis_tready) begin
            o_m_axis_tuser <= 1'b0;
            if (x == X_LAST) begin
              x              <= '0;
              o_m_axis_tlast <= 1'b0;
              if (y == Y_LAST) begin
                state           <= S_DONE;
                o_m_axis_tvalid <= 1'b0;
                o_frame_done    <= 1'b1;
              end else begin
                y <= y + 1'b1;
                if (HBLANK > 0) begin
                  state           <= S_BLANK;
                  o_m_axis_tvalid <= 1'b0;
                  blank_cnt       <= B_INIT;
                end else begin
                  o_m_axis_tdata <= pix(pattern_q, const_q, frame_cnt, '0, y + 1'b1);
                end
              end
            end else begin
              x              <= x + 1'b1;
              o_m_axis_tlast <= ((x + 1'b1) == X_LAST);
              o_m_axis_tdata <= pix(pattern_q, const_q, frame_cnt, x + 1'b1, y);
            end
          end
        end

        S_BLANK: begin
          if (blank_cnt == '0) begin
            state           <= S_ACTIVE;
            o_m_axis_tvalid <= 1'b1;
            o_m_axis_tdata  <= pix(pattern_q, const_q, frame_cnt, '0, y);
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end

        S_DONE: begin
          frame_cnt <= frame_cnt + 1'b1;
          y         <= '0;
          // A stop seen during this frame, including on its final beat, ends free-run here.
          if (cont_q && !stop_flag && !i_stop) begin
            pattern_q       <= i_pattern;
            const_q         <= i_const;
            state           <= S_ACTIVE;
            o_m_axis_tvalid <= 1'b1;
            o_m_axis_tuser  <= 1'b1;
            o_m_axis_tlast  <= 1'b0;
            o_m_axis_tdata  <= pix(i_pattern, i_const, frame_cnt + 1'b1, '0, '0);
          end else begin
            cont_q <= 1'b0;
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roi_axis_frame_source.sv
// Randomised self-checking bench for roi_axis_frame_source against a raster-scan reference model.
module tb_roi_axis_frame_source;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: 4x3 with 2 blanking cycles
  logic       start_a = 0, cont_a = 0, stop_a = 0, tready_a = 1;
  logic [1:0] pat_a = 0;
  logic [7:0] const_a = 0;
  logic       busy_a, fdone_a, tvalid_a, tlast_a, tuser_a;
  logic [7:0] tdata_a;

  // DUT b: 32x16, no blanking
  logic       start_b = 0, cont_b = 0, stop_b = 0, tready_b = 1;
  logic [1:0] pat_b = 0;
  logic [7:0] const_b = 0;
  logic       busy_b, fdone_b, tvalid_b, tlast_b, tuser_b;
  logic [7:0] tdata_b;

  roi_axis_frame_source #(.PIXEL_SIZE(8), .WIDTH(4), .HEIGHT(3), .HBLANK(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_pattern(pat_a), .i_const(const_a),
    .i_continuous(cont_a), .i_stop(stop_a), .o_busy(busy_a), .o_frame_done(fdone_a),
    .o_m_axis_tdata(tdata_a), .o_m_axis_tvalid(tvalid_a), .o_m_axis_tlast(tlast_a),
    .o_m_axis_tuser(tuser_a), .i_m_axis_tready(tready_a));

  roi_axis_frame_source #(.PIXEL_SIZE(8), .WIDTH(32), .HEIGHT(16), .HBLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_pattern(pat_b), .i_const(const_b),
    .i_continuous(cont_b), .i_stop(stop_b), .o_busy(busy_b), .o_frame_done(fdone_b),
    .o_m_axis_tdata(tdata_b), .o_m_axis_tvalid(tvalid_b), .o_m_axis_tlast(tlast_b),
    .o_m_axis_tuser(tuser_b), .i_m_axis_tready(tready_b));

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Beat word = {tuser, tlast, tdata}
  logic [9:0] got_a[$], got_b[$], exp_q[$];
  int         cyc_a[$], cyc_b[$], done_q_a[$];
  int         cyc = 0;
  logic       hold_a = 0;
  logic [9:0] held_a = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      hold_a = 0;
    end else begin
      if (hold_a) begin
        chk("hold_tvalid", tvalid_a, 1);
        chk("hold_word", {tuser_a, tlast_a, tdata_a}, held_a);
      end
      if (tvalid_a && tready_a) begin
        got_a.push_back({tuser_a, tlast_a, tdata_a});
        cyc_a.push_back(cyc);
      end
      if (fdone_a) done_q_a.push_back(cyc);
      hold_a = tvalid_a && !tready_a;
      held_a = {tuser_a, tlast_a, tdata_a};
      if (tvalid_b && tready_b) begin
        got_b.push_back({tuser_b, tlast_b, tdata_b});
        cyc_b.push_back(cyc);
      end
    end
  end

  task automatic model_frame(input int w, input int h, input int pat, input int cst, input int fc);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        int d;
        case (pat)
          0: d = (xx + yy) % 256;
          1: d = (((xx / 8) % 2) != ((yy / 8) % 2)) ? 255 : 0;
          2: d = cst;
          default: d = fc % 256;
        endcase
        exp_q.push_back(10'((((xx == 0) && (yy == 0)) ? 512 : 0) + ((xx == w - 1) ? 256 : 0) + d));
      end
  endtask

  task automatic cmp_beats(input string tag, input logic [9:0] g[$], input logic [9:0] e[$]);
    chk({tag, "_count"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), g[i], e[i]);
  endtask

  task automatic clear_q();
    got_a.delete(); cyc_a.delete(); done_q_a.delete(); exp_q.delete();
    got_b.delete(); cyc_b.delete();
  endtask

  // Called just after a rising edge; leaves the bench just after the edge that accepted start.
  task automatic start_frame_a(input logic [1:0] p, input logic [7:0] c, input logic cont);
    pat_a = p; const_a = c; cont_a = cont; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    chk("start_latency_tvalid", tvalid_a, 1);
    chk("start_sof_tuser", tuser_a, 1);
  endtask

  task automatic run_a(input int budget, input bit rnd, input int stop_at, input int start_at);
    bit stop_sent = 0, start_sent = 0, fin = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      tready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stop_a = 0; start_a = 0;
      if (stop_at >= 0 && !stop_sent && done_q_a.size() == stop_at) begin stop_a = 1; stop_sent = 1; end
      if (start_at >= 0 && !start_sent && got_a.size() == start_at) begin start_a = 1; start_sent = 1; end
      if (!busy_a) begin fin = 1; break; end
    end
    chk("run_a_finished", fin, 1);
    tready_a = 1; stop_a = 0; start_a = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_a", {busy_a, fdone_a, tvalid_a, tlast_a, tuser_a, tdata_a}, 0);
    chk("reset_outputs_b", {busy_b, fdone_b, tvalid_b, tlast_b, tuser_b, tdata_b}, 0);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // 1: single ramp frame, tready high: sequence, blank gaps, frame_done timing
    clear_q();
    start_frame_a(2'd0, 8'd0, 1'b0);
    run_a(200, 0, -1, -1);
    model_frame(4, 3, 0, 0, 0);
    cmp_beats("ramp", got_a, exp_q);
    for (int i = 1; i < cyc_a.size(); i++)
      chk($sformatf("ramp_gap%0d", i), cyc_a[i] - cyc_a[i-1], (i % 4 == 0) ? 3 : 1);
    chk("ramp_done_count", done_q_a.size(), 1);
    if (done_q_a.size() == 1 && cyc_a.size() == 12)
      chk("ramp_done_timing", done_q_a[0], cyc_a[11] + 1);
    chk("ramp_busy_after", busy_a, 0);

    // 2: random backpressure, several frames
    for (int r = 0; r < 3; r++) begin
      clear_q();
      tready_a = 1'($urandom_range(0, 1));
      start_frame_a(2'd0, 8'd0, 1'b0);
      run_a(500, 1, -1, -1);
      model_frame(4, 3, 0, 0, 0);
      cmp_beats($sformatf("bp%0d", r), got_a, exp_q);
    end

    // 3: continuous frame-count pattern, stop during frame 3
    do_reset();
    clear_q();
    start_frame_a(2'd3, 8'd0, 1'b1);
    run_a(500, 0, 2, -1);
    for (int f = 0; f < 3; f++) model_frame(4, 3, 3, 0, f);
    cmp_beats("cont", got_a, exp_q);
    chk("cont_done_count", done_q_a.size(), 3);
    chk("cont_idle_after", busy_a, 0);

    // 4: constant pattern, ignored mid-frame start, then start right after frame_done
    clear_q();
    start_frame_a(2'd2, 8'hA5, 1'b0);
    run_a(200, 0, -1, 5);
    model_frame(4, 3, 2, 8'hA5, 0);
    cmp_beats("const", got_a, exp_q);
    chk("const_done_count", done_q_a.size(), 1);
    clear_q();
    start_frame_a(2'd2, 8'h3C, 1'b0);
    run_a(200, 0, -1, -1);
    model_frame(4, 3, 2, 8'h3C, 0);
    cmp_beats("const_restart", got_a, exp_q);

    // 5: reset mid-frame after beat 6
    clear_q();
    start_frame_a(2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (got_a.size() >= 6) break;
    end
    chk("midreset_beats_seen", got_a.size(), 6);
    rst_n = 0;
    #1;
    chk("midreset_outputs", {busy_a, fdone_a, tvalid_a, tlast_a, tuser_a, tdata_a}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    clear_q();
    start_frame_a(2'd0, 8'd0, 1'b0);
    run_a(200, 0, -1, -1);
    model_frame(4, 3, 0, 0, 0);
    cmp_beats("after_reset", got_a, exp_q);

    // 6: 32x16 checker, no blanking
    clear_q();
    pat_b = 2'd1; tready_b = 1; start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    begin
      bit fin = 0;
      for (int i = 0; i < 2000; i++) begin
        @(posedge clk); #1;
        if (!busy_b) begin fin = 1; break; end
      end
      chk("checker_finished", fin, 1);
    end
    model_frame(32, 16, 1, 0, 0);
    cmp_beats("checker", got_b, exp_q);
    if (cyc_b.size() == 512) chk("checker_no_gaps", cyc_b[511] - cyc_b[0], 511);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
